// File: rtl/sram_mem_arbiter_pkg.sv
// Shared types for the SRAM-like memory arbiter: widths, FSM state and owner
// encodings, and the muxed memory command payload.
package sram_mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef struct packed {
        logic              wr;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/sram_mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the memory.
// slave = arbiter view, master = CPU + memory environment view.
interface sram_mem_arbiter_if;
    import sram_mem_arbiter_pkg::*;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_wr;
    logic [STRB_W-1:0] data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_req;
    logic              mem_wr;
    logic [STRB_W-1:0] mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/sram_mem_arbiter.sv
// Merges instruction-fetch and data SRAM-like ports onto one single-port memory
// channel with one outstanding transaction; data wins unless fetch is starving.
module sram_mem_arbiter
    import sram_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    sram_mem_arbiter_if.slave bus,
    output logic              err
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_e           state;
    state_e           state_nxt;
    owner_e           owner;
    owner_e           gnt_c;
    owner_e           lock_owner;
    logic             lock_vld;
    logic [CNT_W-1:0] starve_cnt;
    logic             req_any_c;
    logic             accept_c;
    logic             stall_c;
    mem_cmd_t         cmd_c;

    assign req_any_c = bus.inst_req | bus.data_req;

    // Grant selection; a stalled request keeps its grant until memory takes it.
    always_comb begin
        gnt_c = OWN_INST;
        if (lock_vld) begin
            gnt_c = lock_owner;
        end else if (bus.data_req && !(bus.inst_req && starve_cnt == CNT_MAX)) begin
            gnt_c = OWN_DATA;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt        = state;
        accept_c         = 1'b0;
        stall_c          = 1'b0;
        cmd_c            = '0;
        bus.mem_req      = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = '0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = '0;

        case (state)
            ST_IDLE: begin
                if (req_any_c) begin
                    bus.mem_req = 1'b1;
                    if (gnt_c == OWN_DATA) begin
                        cmd_c = '{wr:    bus.data_wr,
                                  wstrb: bus.data_wstrb,
                                  addr:  bus.data_addr,
                                  wdata: bus.data_wdata};
                    end else begin
                        cmd_c.addr = bus.inst_addr;
                    end
                    if (bus.mem_ready) begin
                        accept_c  = 1'b1;
                        state_nxt = ST_WAIT;
                        if (gnt_c == OWN_DATA) begin
                            bus.data_addr_ok = 1'b1;
                        end else begin
                            bus.inst_addr_ok = 1'b1;
                        end
                    end else begin
                        stall_c = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_nxt = ST_IDLE;
                    if (owner == OWN_DATA) begin
                        bus.data_data_ok = 1'b1;
                        bus.data_rdata   = bus.mem_rdata;
                    end else begin
                        bus.inst_data_ok = 1'b1;
                        bus.inst_rdata   = bus.mem_rdata;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        bus.mem_wr    = cmd_c.wr;
        bus.mem_wstrb = cmd_c.wstrb;
        bus.mem_addr  = cmd_c.addr;
        bus.mem_wdata = cmd_c.wdata;
    end

    // State, owner, grant lock, starvation counter and sticky stray-response error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_INST;
            lock_vld   <= 1'b0;
            lock_owner <= OWN_INST;
            starve_cnt <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            lock_vld   <= stall_c;
            lock_owner <= gnt_c;
            if (accept_c) begin
                owner <= gnt_c;
            end
            if (!bus.inst_req || (accept_c && gnt_c == OWN_INST)) begin
                starve_cnt <= '0;
            end else if (accept_c && gnt_c == OWN_DATA && starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
            if (state == ST_IDLE && bus.mem_rvalid) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Directed bench for sram_mem_arbiter: bench acts as CPU and memory, expected
// responses queue up at request acceptance and are checked on data_ok.
module tb_sram_mem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic clk = 1'b0;
    logic reset;
    logic err;
    int   checks   = 0;
    int   failures = 0;

    bit          exp_own_q[$];
    logic [31:0] exp_data_q[$];

    sram_mem_arbiter_if bus ();

    sram_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = '0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_wstrb = '0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic chk_quiet(input string tag, input logic exp_err);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'(0));
        chk({tag, "_addr_ok"}, 32'({bus.inst_addr_ok, bus.data_addr_ok}), 32'(0));
        chk({tag, "_data_ok"}, 32'({bus.inst_data_ok, bus.data_data_ok}), 32'(0));
        chk({tag, "_inst_rdata"}, bus.inst_rdata, 32'(0));
        chk({tag, "_data_rdata"}, bus.data_rdata, 32'(0));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    // Called at a negedge with requests driven; returns at the next negedge.
    task automatic expect_accept(input bit own, input logic [31:0] addr, input logic [31:0] rdata);
        #1;
        chk("mem_req", 32'(bus.mem_req), 32'(1));
        chk("mem_addr", bus.mem_addr, addr);
        chk("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(!own));
        chk("data_addr_ok", 32'(bus.data_addr_ok), 32'(own));
        exp_own_q.push_back(own);
        exp_data_q.push_back(rdata);
        @(negedge clk);
    endtask

    // Memory returns a response this cycle; checked against the scoreboard head.
    task automatic respond(input logic [31:0] rdata);
        bit          own;
        logic [31:0] exp_d;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        #1;
        chk("wait_mem_req", 32'(bus.mem_req), 32'(0));
        chk("wait_addr_ok", 32'({bus.inst_addr_ok, bus.data_addr_ok}), 32'(0));
        checks++;
        assert (exp_own_q.size() != 0) else begin
            failures++;
            $error("FAIL sb_underflow observed=response expected=no_outstanding");
        end
        if (exp_own_q.size() != 0) begin
            own   = exp_own_q.pop_front();
            exp_d = exp_data_q.pop_front();
            chk("inst_data_ok", 32'(bus.inst_data_ok), 32'(!own));
            chk("data_data_ok", 32'(bus.data_data_ok), 32'(own));
            chk("rdata", own ? bus.data_rdata : bus.inst_rdata, exp_d);
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit own;

        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_quiet("reset", 1'b0);
        @(negedge clk);

        // Single fetch with minimum latency.
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1c00_0000;
        bus.mem_ready = 1'b1;
        expect_accept(1'b0, 32'h1c00_0000, 32'h0280_0c0c);
        bus.inst_req = 1'b0;
        respond(32'h0280_0c0c);

        // Simultaneous fetch and load: load first, fetch after its data_ok.
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1c00_0004;
        bus.data_req  = 1'b1;
        bus.data_wr   = 1'b0;
        bus.data_addr = 32'h0000_1000;
        expect_accept(1'b1, 32'h0000_1000, 32'h1111_2222);
        bus.data_req = 1'b0;
        respond(32'h1111_2222);
        expect_accept(1'b0, 32'h1c00_0004, 32'h3333_4444);
        bus.inst_req = 1'b0;
        respond(32'h3333_4444);

        // Anti-starvation: LIMIT data grants, then the pending fetch.
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1c00_0100;
        bus.data_req  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            own           = (i != 4);
            bus.data_addr = 32'h0000_2000 + 32'(i * 4);
            if (i == 4) begin
                chk("starve_at_limit", 32'(dut.starve_cnt), LIMIT);
            end
            expect_accept(own, own ? bus.data_addr : bus.inst_addr, 32'hc0de_0000 + 32'(i));
            if (!own) begin
                bus.inst_req = 1'b0;
                chk("starve_cleared", 32'(dut.starve_cnt), 32'(0));
            end
            if (i == 6) begin
                bus.data_req = 1'b0;
            end
            respond(32'hc0de_0000 + 32'(i));
        end

        // Store stalled by memory for 3 cycles: command must hold steady.
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_wstrb = 4'b0011;
        bus.data_addr  = 32'h0000_3000;
        bus.data_wdata = 32'hdead_beef;
        bus.mem_ready  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_mem_req", 32'(bus.mem_req), 32'(1));
            chk("stall_mem_wr", 32'(bus.mem_wr), 32'(1));
            chk("stall_wstrb", 32'(bus.mem_wstrb), 32'(4'b0011));
            chk("stall_addr", bus.mem_addr, 32'h0000_3000);
            chk("stall_wdata", bus.mem_wdata, 32'hdead_beef);
            chk("stall_addr_ok", 32'(bus.data_addr_ok), 32'(0));
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        expect_accept(1'b1, 32'h0000_3000, 32'h0000_0000);
        bus.data_req = 1'b0;
        bus.data_wr  = 1'b0;
        respond(32'h0000_0000);

        // Stalled fetch keeps its grant when a load arrives mid-stall.
        bus.mem_ready = 1'b0;
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1c00_0200;
        #1;
        chk("lock_first_addr", bus.mem_addr, 32'h1c00_0200);
        @(negedge clk);
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h0000_4000;
        #1;
        chk("lock_held_addr", bus.mem_addr, 32'h1c00_0200);
        chk("lock_held_wr", 32'(bus.mem_wr), 32'(0));
        @(negedge clk);
        bus.mem_ready = 1'b1;
        expect_accept(1'b0, 32'h1c00_0200, 32'h5555_0000);
        bus.inst_req = 1'b0;
        respond(32'h5555_0000);
        expect_accept(1'b1, 32'h0000_4000, 32'h6666_0000);
        bus.data_req = 1'b0;
        respond(32'h6666_0000);

        // Stray response in IDLE: no data_ok, sticky err.
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_beef;
        #1;
        chk("stray_data_ok", 32'({bus.inst_data_ok, bus.data_data_ok}), 32'(0));
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        #1;
        chk("err_set", 32'(err), 32'(1));
        repeat (3) @(negedge clk);
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1c00_0300;
        expect_accept(1'b0, 32'h1c00_0300, 32'h7777_0000);
        bus.inst_req = 1'b0;
        respond(32'h7777_0000);
        #1;
        chk("err_sticky", 32'(err), 32'(1));
        @(negedge clk);

        // Reset while waiting for a response: clean IDLE, then normal operation.
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1c00_0400;
        expect_accept(1'b0, 32'h1c00_0400, 32'h8888_0000);
        bus.inst_req = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_own_q.delete();
        exp_data_q.delete();
        #1;
        chk_quiet("mid_reset", 1'b0);
        @(negedge clk);
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h1c00_0500;
        expect_accept(1'b0, 32'h1c00_0500, 32'h9999_0000);
        bus.inst_req = 1'b0;
        respond(32'h9999_0000);
        #1;
        chk("post_reset_err", 32'(err), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
